// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mac_pkg
// Brief   : Shared Ethernet MAC constants and framer state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package mac_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PREAMBLE = 4'd1,
        ST_DST_ADDR = 4'd2,
        ST_SRC_ADDR = 4'd3,
        ST_PROTO    = 4'd4,
        ST_PAYLOAD  = 4'd5,
        ST_PAD      = 4'd6,
        ST_FCS      = 4'd7,
        ST_GAP      = 4'd8
    } mac_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
    localparam logic [15:0] ETHERTYPE_IP  = 16'h0800;
    localparam int          MIN_PAYLOAD   = 46;
    localparam logic [31:0] CRC_PRESET    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;

endpackage
`default_nettype wire

// File: rtl/crc32_byte.sv
`default_nettype none
// ============================================================================
// Module  : crc32_byte
// Brief   : Combinational reflected CRC-32 update by one data byte.
// Revision: 1.0 - initial release
// ============================================================================
module crc32_byte
    import mac_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_work;

    always_comb begin
        crc_work = crc_i ^ {24'h000000, data_i};
        for (int i = 0; i < 8; i++) begin
            crc_work = crc_work[0] ? ((crc_work >> 1) ^ CRC_POLY) : (crc_work >> 1);
        end
        crc_o = crc_work;
    end

endmodule
`default_nettype wire

// File: rtl/mac_send_frame.sv
`default_nettype none
// ============================================================================
// Module  : mac_send_frame
// Brief   : Ethernet transmit framer: preamble, header, payload, pad, FCS, IFG.
// Revision: 1.0 - initial release
// ============================================================================
module mac_send_frame
    import mac_pkg::*;
#(
    parameter int MAX_PAYLOAD = 1500,
    parameter int IFG_BYTES   = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tx_request,
    input  logic        is_arp,
    input  logic [47:0] remote_mac,
    input  logic [47:0] local_mac,
    input  logic [10:0] payload_length,
    input  logic [7:0]  payload_data,
    output logic        payload_rd,
    output logic        tx_ack,
    output logic        tx_done,
    output logic        tx_enable,
    output logic [7:0]  tx_data
);

    localparam logic [10:0] MAX_LEN  = 11'(MAX_PAYLOAD);
    localparam logic [10:0] MIN_LEN  = 11'(MIN_PAYLOAD);
    localparam logic [10:0] GAP_LAST = 11'(IFG_BYTES - 1);

    // state_q names the byte currently on tx_data; the comb block picks the next one.
    mac_state_t  state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [10:0] len_q, len_d;
    logic        arp_q, arp_d;
    logic [47:0] sh_q, sh_d;
    logic [31:0] crc_q;
    logic        en_q, en_d;
    logic [7:0]  data_q, data_d;
    logic        rd_q, rd_d;
    logic        ack_q, ack_d;
    logic        done_q, done_d;
    logic        crc_upd, crc_shift, start_ok;
    logic [31:0] crc_seed, crc_next;

    crc32_byte u_crc (
        .crc_i  (crc_seed),
        .data_i (data_d),
        .crc_o  (crc_next)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        arp_d     = arp_q;
        sh_d      = sh_q;
        en_d      = 1'b1;
        data_d    = 8'h00;
        rd_d      = 1'b0;
        ack_d     = 1'b0;
        done_d    = 1'b0;
        crc_upd   = 1'b0;
        crc_shift = 1'b0;
        crc_seed  = crc_q;
        start_ok  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                en_d     = 1'b0;
                start_ok = 1'b1;
            end
            ST_PREAMBLE: begin
                if (cnt_q == 11'd7) begin
                    state_d  = ST_DST_ADDR;
                    data_d   = sh_q[47:40];
                    sh_d     = sh_q << 8;
                    cnt_d    = 11'd5;
                    crc_seed = CRC_PRESET;
                    crc_upd  = 1'b1;
                end else begin
                    data_d = (cnt_q == 11'd6) ? SFD_BYTE : PREAMBLE_BYTE;
                    cnt_d  = cnt_q + 11'd1;
                end
            end
            ST_DST_ADDR, ST_SRC_ADDR: begin
                crc_upd = 1'b1;
                if (cnt_q != 11'd0) begin
                    data_d = sh_q[47:40];
                    sh_d   = sh_q << 8;
                    cnt_d  = cnt_q - 11'd1;
                end else if (state_q == ST_DST_ADDR) begin
                    state_d = ST_SRC_ADDR;
                    data_d  = local_mac[47:40];
                    sh_d    = local_mac << 8;
                    cnt_d   = 11'd5;
                end else begin
                    state_d = ST_PROTO;
                    data_d  = ETHERTYPE_ARP[15:8];
                    cnt_d   = 11'd1;
                end
            end
            ST_PROTO: begin
                crc_upd = 1'b1;
                if (cnt_q == 11'd1) begin
                    data_d = arp_q ? ETHERTYPE_ARP[7:0] : ETHERTYPE_IP[7:0];
                    cnt_d  = 11'd0;
                    rd_d   = (len_q != 11'd0);
                end else begin
                    // cnt now counts payload+pad bytes already emitted
                    cnt_d = 11'd1;
                    if (len_q != 11'd0) begin
                        state_d = ST_PAYLOAD;
                        data_d  = payload_data;
                        rd_d    = (len_q > 11'd1);
                    end else begin
                        state_d = ST_PAD;
                    end
                end
            end
            ST_PAYLOAD, ST_PAD: begin
                if (state_q == ST_PAYLOAD && cnt_q < len_q) begin
                    data_d  = payload_data;
                    cnt_d   = cnt_q + 11'd1;
                    rd_d    = ((cnt_q + 11'd1) < len_q);
                    crc_upd = 1'b1;
                end else if (cnt_q < MIN_LEN) begin
                    state_d = ST_PAD;
                    cnt_d   = cnt_q + 11'd1;
                    crc_upd = 1'b1;
                end else begin
                    state_d   = ST_FCS;
                    data_d    = ~crc_q[7:0];
                    crc_shift = 1'b1;
                    cnt_d     = 11'd0;
                end
            end
            ST_FCS: begin
                if (cnt_q < 11'd3) begin
                    data_d    = ~crc_q[7:0];
                    crc_shift = 1'b1;
                    cnt_d     = cnt_q + 11'd1;
                end else begin
                    state_d = ST_GAP;
                    en_d    = 1'b0;
                    cnt_d   = 11'd0;
                    done_d  = (GAP_LAST == 11'd0);
                end
            end
            ST_GAP: begin
                en_d = 1'b0;
                // The last gap cycle doubles as the idle sampling cycle.
                if (cnt_q == GAP_LAST) begin
                    state_d  = ST_IDLE;
                    start_ok = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 11'd1;
                    done_d = ((cnt_q + 11'd1) == GAP_LAST);
                end
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = 1'b0;
            end
        endcase
        if (start_ok && tx_request) begin
            state_d = ST_PREAMBLE;
            cnt_d   = 11'd0;
            en_d    = 1'b1;
            data_d  = PREAMBLE_BYTE;
            ack_d   = 1'b1;
            arp_d   = is_arp;
            sh_d    = remote_mac;
            len_d   = (payload_length > MAX_LEN) ? MAX_LEN : payload_length;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 11'd0;
            len_q   <= 11'd0;
            arp_q   <= 1'b0;
            sh_q    <= 48'h0;
            crc_q   <= CRC_PRESET;
            en_q    <= 1'b0;
            data_q  <= 8'h00;
            rd_q    <= 1'b0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            arp_q   <= arp_d;
            sh_q    <= sh_d;
            if (crc_upd) begin
                crc_q <= crc_next;
            end else if (crc_shift) begin
                crc_q <= crc_q >> 8;
            end
            en_q    <= en_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
        end
    end

    assign tx_enable  = en_q;
    assign tx_data    = data_q;
    assign payload_rd = rd_q;
    assign tx_ack     = ack_q;
    assign tx_done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_send_frame.sv
`default_nettype none
// ============================================================================
// Module  : tb_mac_send_frame
// Brief   : Directed self-checking bench for the Ethernet transmit framer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mac_send_frame;

    localparam logic [47:0] LOCAL_MAC = 48'h001CC0A213DD;
    localparam logic [31:0] RESIDUE   = 32'hDEBB20E3;

    logic        clock = 1'b0;
    logic        reset;
    logic        tx_request;
    logic        is_arp;
    logic [47:0] remote_mac;
    logic [47:0] local_mac;
    logic [10:0] payload_length;
    logic [7:0]  payload_data;
    logic        payload_rd;
    logic        tx_ack;
    logic        tx_done;
    logic        tx_enable;
    logic [7:0]  tx_data;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          pay_idx = 0;
    logic [7:0]  fb [0:2047];

    mac_send_frame #(.MAX_PAYLOAD(1500), .IFG_BYTES(12)) dut (
        .clock          (clock),
        .reset          (reset),
        .tx_request     (tx_request),
        .is_arp         (is_arp),
        .remote_mac     (remote_mac),
        .local_mac      (local_mac),
        .payload_length (payload_length),
        .payload_data   (payload_data),
        .payload_rd     (payload_rd),
        .tx_ack         (tx_ack),
        .tx_done        (tx_done),
        .tx_enable      (tx_enable),
        .tx_data        (tx_data)
    );

    always #5 clock = ~clock;

    // Upstream FWFT source: byte k of each frame is k mod 256.
    always @(posedge clock) begin
        if (tx_ack)          pay_idx <= 0;
        else if (payload_rd) pay_idx <= pay_idx + 1;
    end
    assign payload_data = pay_idx[7:0];

    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input string tag, input logic arp, input logic [47:0] mac,
                             input logic [10:0] len, input int exp_l, input logic hold);
        int n, gap, bubble, rd_cnt, echo_err, extra_ack, pre_err, pad_err, pay_err, data_len;
        logic prev_rd, done;
        logic [7:0] prev_pd;
        logic [31:0] c;
        data_len = (exp_l < 46) ? 46 : exp_l;
        tx_request = 1'b1; is_arp = arp; remote_mac = mac; payload_length = len;
        @(posedge clock); #1;
        chk({tag, ".ack"}, 48'(tx_ack), 48'd1);
        chk({tag, ".sop"}, 48'({tx_enable, tx_data}), 48'h155);
        if (!hold) tx_request = 1'b0;
        is_arp = ~arp; remote_mac = ~mac; payload_length = 11'd3;
        n = 0; fb[n] = tx_data; n++;
        gap = 0; bubble = 0; rd_cnt = 0; echo_err = 0; extra_ack = 0; done = 1'b0;
        prev_rd = payload_rd; prev_pd = payload_data;
        if (payload_rd) rd_cnt++;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            @(posedge clock); #1;
            if (prev_rd && (tx_data !== prev_pd || tx_enable !== 1'b1)) echo_err++;
            if (tx_ack) extra_ack++;
            if (tx_enable) begin
                if (gap > 0) bubble++;
                if (n < 2048) fb[n] = tx_data;
                n++;
            end else begin
                gap++;
            end
            if (payload_rd) rd_cnt++;
            prev_rd = payload_rd; prev_pd = payload_data;
            if (tx_done) done = 1'b1;
        end
        chk({tag, ".done"}, 48'(done), 48'd1);
        chk({tag, ".en_cycles"}, 48'(n), 48'(26 + data_len));
        chk({tag, ".bubbles"}, 48'(bubble), 48'd0);
        chk({tag, ".gap"}, 48'(gap), 48'd12);
        chk({tag, ".strobes"}, 48'(rd_cnt), 48'(exp_l));
        chk({tag, ".echo_err"}, 48'(echo_err), 48'd0);
        chk({tag, ".extra_ack"}, 48'(extra_ack), 48'd0);
        pre_err = 0;
        for (int i = 0; i < 7; i++) if (fb[i] !== 8'h55) pre_err++;
        if (fb[7] !== 8'hD5) pre_err++;
        chk({tag, ".preamble_err"}, 48'(pre_err), 48'd0);
        chk({tag, ".dst"}, {fb[8], fb[9], fb[10], fb[11], fb[12], fb[13]}, mac);
        chk({tag, ".src"}, {fb[14], fb[15], fb[16], fb[17], fb[18], fb[19]}, LOCAL_MAC);
        chk({tag, ".ethertype"}, 48'({fb[20], fb[21]}), arp ? 48'h0806 : 48'h0800);
        pay_err = 0;
        for (int i = 0; i < exp_l; i++) if (fb[22 + i] !== i[7:0]) pay_err++;
        chk({tag, ".payload_err"}, 48'(pay_err), 48'd0);
        pad_err = 0;
        for (int i = exp_l; i < data_len; i++) if (fb[22 + i] !== 8'h00) pad_err++;
        chk({tag, ".pad_err"}, 48'(pad_err), 48'd0);
        c = 32'hFFFFFFFF;
        for (int i = 8; i < n && i < 2048; i++) c = crc_step(c, fb[i]);
        chk({tag, ".crc_residue"}, 48'(c), 48'(RESIDUE));
    endtask

    initial begin
        int strobes, cnt_done, cnt_en;
        reset = 1'b1; tx_request = 1'b0; is_arp = 1'b0; remote_mac = 48'h0;
        local_mac = LOCAL_MAC; payload_length = 11'd0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset.outputs", 48'({tx_enable, tx_data, payload_rd, tx_ack, tx_done}), 48'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("idle.outputs", 48'({tx_enable, tx_data, payload_rd, tx_ack, tx_done}), 48'd0);

        run_frame("arp28",  1'b1, 48'hFFFFFFFFFFFF, 11'd28,   28,   1'b0);
        run_frame("ip1500", 1'b0, 48'h021122334455, 11'd1500, 1500, 1'b0);
        run_frame("len0",   1'b0, 48'h0A0B0C0D0E0F, 11'd0,    0,    1'b0);
        run_frame("clip",   1'b0, 48'h021122334455, 11'd2047, 1500, 1'b0);
        run_frame("b2b_a",  1'b0, 48'h112233445566, 11'd46,   46,   1'b1);
        run_frame("b2b_b",  1'b1, 48'h112233445566, 11'd47,   47,   1'b0);

        // Abort a frame while its 10th payload byte is on the wire.
        tx_request = 1'b1; is_arp = 1'b0; remote_mac = 48'hA1A2A3A4A5A6; payload_length = 11'd100;
        @(posedge clock); #1;
        chk("abort.ack", 48'(tx_ack), 48'd1);
        tx_request = 1'b0;
        strobes = 0;
        for (int cyc = 0; cyc < 200 && strobes < 10; cyc++) begin
            @(posedge clock); #1;
            if (payload_rd) strobes++;
        end
        @(posedge clock); #1;
        chk("abort.byte10", 48'({tx_enable, tx_data}), 48'h109);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("abort.outputs", 48'({tx_enable, tx_data, payload_rd, tx_ack, tx_done}), 48'd0);
        reset = 1'b0;
        cnt_done = 0; cnt_en = 0;
        repeat (60) begin
            @(posedge clock); #1;
            if (tx_done) cnt_done++;
            if (tx_enable) cnt_en++;
        end
        chk("abort.no_done", 48'(cnt_done), 48'd0);
        chk("abort.no_enable", 48'(cnt_en), 48'd0);
        run_frame("post_abort_n100", 1'b1, 48'h665544332211, 11'd100, 100, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
